// File: rtl/obi_arb_pkg.sv
// Shared types for the OBI round-robin arbiter.
package obi_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      RESP
   } arb_state_e;

   localparam int unsigned MAX_REQ = 8;

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner selection: rotate by the priority pointer, find-first, rotate back.
module rr_pick
   import obi_arb_pkg::*;
#(
   parameter  int unsigned NUM_REQ = 2,
   localparam int unsigned IDXW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDXW-1:0]    prio,
   output logic [IDXW-1:0]    winner,
   output logic               any_valid
);

   logic [2*NUM_REQ-1:0] dbl;
   logic [NUM_REQ-1:0]   rot;
   logic [IDXW-1:0]      first;
   logic                 found;
   logic [IDXW:0]        sum;

   always_comb begin
      dbl   = {req, req};
      // rot[i] corresponds to initiator (i + prio) mod NUM_REQ
      rot   = dbl[prio +: NUM_REQ];
      first = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (rot[i] && !found) begin
            found = 1'b1;
            first = IDXW'(i);
         end
      end
      sum = {1'b0, first} + {1'b0, prio};
      if (sum >= (IDXW + 1)'(NUM_REQ)) begin
         sum = sum - (IDXW + 1)'(NUM_REQ);
      end
      winner    = sum[IDXW-1:0];
      any_valid = |req;
   end

endmodule

// File: rtl/obi_rr_arbiter.sv
// Round-robin arbiter sharing one OBI target between NUM_REQ initiators, one transaction in
// flight, with the response routed back to the winning initiator.
module obi_rr_arbiter
   import obi_arb_pkg::*;
#(
   parameter  int unsigned NUM_REQ   = 2,
   parameter  int unsigned OBI_ADDRW = 32,
   parameter  int unsigned OBI_DATAW = 32,
   parameter  int unsigned OBI_STRBW = OBI_DATAW / 8,
   localparam int unsigned IDXW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                           clk_i,
   input  logic                           arst_ni,
   input  logic [NUM_REQ-1:0]             m_req_i,
   output logic [NUM_REQ-1:0]             m_gnt_o,
   output logic [NUM_REQ-1:0]             m_rvalid_o,
   input  logic [NUM_REQ-1:0]             m_we_i,
   input  logic [NUM_REQ*OBI_STRBW-1:0]   m_be_i,
   input  logic [NUM_REQ*OBI_ADDRW-1:0]   m_addr_i,
   input  logic [NUM_REQ*OBI_DATAW-1:0]   m_wdata_i,
   output logic [OBI_DATAW-1:0]           m_rdata_o,
   output logic                           s_req_o,
   input  logic                           s_gnt_i,
   input  logic                           s_rvalid_i,
   output logic                           s_we_o,
   output logic [OBI_STRBW-1:0]           s_be_o,
   output logic [OBI_ADDRW-1:0]           s_addr_o,
   output logic [OBI_DATAW-1:0]           s_wdata_o,
   input  logic [OBI_DATAW-1:0]           s_rdata_i
);

   arb_state_e      state_q, state_d;
   logic [IDXW-1:0] sel_q, sel_d;
   logic [IDXW-1:0] prio_q, prio_d;
   logic [IDXW-1:0] winner;
   logic            any_valid;

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .req       (m_req_i),
      .prio      (prio_q),
      .winner    (winner),
      .any_valid (any_valid)
   );

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         state_q <= IDLE;
         sel_q   <= '0;
         prio_q  <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         prio_q  <= prio_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      prio_d     = prio_q;
      s_req_o    = 1'b0;
      m_gnt_o    = '0;
      m_rvalid_o = '0;
      unique case (state_q)
         IDLE: begin
            if (any_valid) begin
               sel_d   = winner;
               state_d = ADDR;
            end
         end
         ADDR: begin
            // Winner stays locked until granted, even if it drops its request.
            s_req_o = 1'b1;
            if (s_gnt_i) begin
               m_gnt_o[sel_q] = 1'b1;
               prio_d = (sel_q == IDXW'(NUM_REQ - 1)) ? '0 : sel_q + 1'b1;
               if (s_rvalid_i) begin
                  m_rvalid_o[sel_q] = 1'b1;
                  state_d           = IDLE;
               end else begin
                  state_d = RESP;
               end
            end
         end
         RESP: begin
            if (s_rvalid_i) begin
               m_rvalid_o[sel_q] = 1'b1;
               state_d           = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      s_we_o    = m_we_i[0];
      s_be_o    = m_be_i[OBI_STRBW-1:0];
      s_addr_o  = m_addr_i[OBI_ADDRW-1:0];
      s_wdata_o = m_wdata_i[OBI_DATAW-1:0];
      for (int i = 1; i < NUM_REQ; i++) begin
         if (sel_q == IDXW'(i)) begin
            s_we_o    = m_we_i[i];
            s_be_o    = m_be_i[i*OBI_STRBW +: OBI_STRBW];
            s_addr_o  = m_addr_i[i*OBI_ADDRW +: OBI_ADDRW];
            s_wdata_o = m_wdata_i[i*OBI_DATAW +: OBI_DATAW];
         end
      end
   end

   assign m_rdata_o = s_rdata_i;

`ifdef SIM
   logic inflight_q;

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         inflight_q <= 1'b0;
      end else if (|m_gnt_o && !(|m_rvalid_o)) begin
         inflight_q <= 1'b1;
      end else if (|m_rvalid_o) begin
         inflight_q <= 1'b0;
      end
   end

   assert property (@(posedge clk_i) disable iff (!arst_ni) $onehot0(m_gnt_o));
   assert property (@(posedge clk_i) disable iff (!arst_ni) $onehot0(m_rvalid_o));
   assert property (@(posedge clk_i) disable iff (!arst_ni) |m_gnt_o |-> !inflight_q);
   assert property (@(posedge clk_i) disable iff (!arst_ni)
                    |m_rvalid_o |-> (|m_gnt_o || inflight_q));
   assert property (@(posedge clk_i) disable iff (!arst_ni)
                    (state_q == ADDR && !s_gnt_i) |-> !s_rvalid_i)
      else $error("target rvalid in address phase without gnt");
`endif

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Randomized bench for obi_rr_arbiter against a transaction-level round-robin model.
module tb_obi_rr_arbiter;

   localparam int unsigned N  = 3;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = DW / 8;

   logic              clk = 1'b0;
   logic              arst_n;
   logic [N-1:0]      m_req, m_gnt, m_rvalid, m_we;
   logic [N*SW-1:0]   m_be;
   logic [N*AW-1:0]   m_addr;
   logic [N*DW-1:0]   m_wdata;
   logic [DW-1:0]     m_rdata;
   logic              s_req, s_gnt, s_rvalid, s_we;
   logic [SW-1:0]     s_be;
   logic [AW-1:0]     s_addr;
   logic [DW-1:0]     s_wdata, s_rdata;

   always #5 clk = ~clk;

   obi_rr_arbiter #(
      .NUM_REQ   (N),
      .OBI_ADDRW (AW),
      .OBI_DATAW (DW)
   ) dut (
      .clk_i      (clk),
      .arst_ni    (arst_n),
      .m_req_i    (m_req),
      .m_gnt_o    (m_gnt),
      .m_rvalid_o (m_rvalid),
      .m_we_i     (m_we),
      .m_be_i     (m_be),
      .m_addr_i   (m_addr),
      .m_wdata_i  (m_wdata),
      .m_rdata_o  (m_rdata),
      .s_req_o    (s_req),
      .s_gnt_i    (s_gnt),
      .s_rvalid_i (s_rvalid),
      .s_we_o     (s_we),
      .s_be_o     (s_be),
      .s_addr_o   (s_addr),
      .s_wdata_o  (s_wdata),
      .s_rdata_i  (s_rdata)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Transaction-level model state
   int           ptr;
   bit           pend;
   int           owner;
   int           win;
   bit           prev_idle;
   bit           prev_sreq;
   bit           prev_gnt;
   logic [N-1:0] prev_req;
   logic [N-1:0] drop;
   logic [N-1:0] req_mask;
   int           p_gnt;
   int           grants [N];

   function automatic int pick(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) begin
         int j = (p + k) % N;
         if (r[j]) return j;
      end
      return 0;
   endfunction

   task automatic model_reset();
      ptr       = 0;
      pend      = 1'b0;
      owner     = 0;
      win       = 0;
      prev_idle = 1'b1;
      prev_sreq = 1'b0;
      prev_gnt  = 1'b0;
      prev_req  = '0;
      drop      = '0;
   endtask

   task automatic cycle();
      bit           exp_sreq, was_pend;
      logic [N-1:0] exp_gnt, exp_rv;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         if (drop[i]) m_req[i] = 1'b0;
         if (!m_req[i] && req_mask[i] && $urandom_range(2) == 0) begin
            m_req[i]                 = 1'b1;
            m_we[i]                  = 1'($urandom);
            m_be[i*SW +: SW]         = SW'($urandom);
            m_addr[i*AW +: AW]       = $urandom;
            m_wdata[i*DW +: DW]      = $urandom;
         end
      end
      drop = '0;
      exp_sreq = (prev_idle && |prev_req) || (prev_sreq && !prev_gnt);
      if (prev_idle && |prev_req) win = pick(prev_req, ptr);
      was_pend = pend;
      // Target: gnt is random everywhere (ignored outside the address phase); stray rvalid
      // only when no address phase is open, so the target never violates OBI.
      s_gnt   = ($urandom_range(99) < p_gnt);
      s_rdata = $urandom;
      if (was_pend)      s_rvalid = ($urandom_range(3) == 0);
      else if (exp_sreq) s_rvalid = s_gnt && ($urandom_range(1) == 0);
      else               s_rvalid = ($urandom_range(3) == 0);
      #1;
      check("s_req", 64'(s_req), 64'(exp_sreq));
      check("rdata", 64'(m_rdata), 64'(s_rdata));
      exp_gnt = '0;
      exp_rv  = '0;
      if (exp_sreq && s_gnt) begin
         exp_gnt[win] = 1'b1;
         drop[win]    = 1'b1;
         grants[win]++;
         ptr = (win + 1) % N;
         if (s_rvalid) exp_rv[win] = 1'b1;
         else begin
            pend  = 1'b1;
            owner = win;
         end
      end else if (was_pend && s_rvalid) begin
         exp_rv[owner] = 1'b1;
         pend          = 1'b0;
      end
      check("gnt", 64'(m_gnt), 64'(exp_gnt));
      check("rvalid", 64'(m_rvalid), 64'(exp_rv));
      if (exp_sreq) begin
         check("fwd_we", 64'(s_we), 64'(m_we[win]));
         check("fwd_be", 64'(s_be), 64'(m_be[win*SW +: SW]));
         check("fwd_addr", 64'(s_addr), 64'(m_addr[win*AW +: AW]));
         check("fwd_wdata", 64'(s_wdata), 64'(m_wdata[win*DW +: DW]));
      end
      prev_idle = !exp_sreq && !was_pend;
      prev_sreq = exp_sreq;
      prev_gnt  = s_gnt;
      prev_req  = m_req;
   endtask

   initial begin
      int guard;
      arst_n   = 1'b0;
      m_req    = '0;
      m_we     = '0;
      m_be     = '0;
      m_addr   = '0;
      m_wdata  = '0;
      s_gnt    = 1'b1;
      s_rvalid = 1'b1;
      s_rdata  = '0;
      req_mask = '1;
      p_gnt    = 50;
      for (int i = 0; i < N; i++) grants[i] = 0;
      model_reset();

      repeat (2) @(posedge clk);
      #1;
      check("rst_s_req", 64'(s_req), 64'(0));
      check("rst_gnt", 64'(m_gnt), 64'(0));
      check("rst_rvalid", 64'(m_rvalid), 64'(0));
      @(negedge clk);
      s_gnt    = 1'b0;
      s_rvalid = 1'b0;
      arst_n   = 1'b1;

      // Balanced, then long gnt stalls (winner lock), then fast target
      repeat (800) cycle();
      p_gnt = 8;
      repeat (800) cycle();
      p_gnt = 95;
      repeat (800) cycle();
      for (int i = 0; i < N; i++) check($sformatf("served_%0d", i), 64'(grants[i] > 0), 64'(1));

      // Reset in the middle of a split response
      p_gnt = 60;
      guard = 0;
      while (!pend && guard < 500) begin
         cycle();
         guard++;
      end
      check("reach_resp", 64'(pend), 64'(1));
      @(negedge clk);
      s_gnt    = 1'b1;
      s_rvalid = 1'b1;
      arst_n   = 1'b0;
      #1;
      check("midrst_s_req", 64'(s_req), 64'(0));
      check("midrst_gnt", 64'(m_gnt), 64'(0));
      check("midrst_rvalid", 64'(m_rvalid), 64'(0));
      @(negedge clk);
      s_gnt    = 1'b0;
      s_rvalid = 1'b0;
      m_req    = '0;
      arst_n   = 1'b1;
      model_reset();
      req_mask = 3'b010;
      for (int i = 0; i < N; i++) grants[i] = 0;
      repeat (100) cycle();
      check("post_rst_served_1", 64'(grants[1] > 0), 64'(1));
      check("post_rst_no_0", 64'(grants[0]), 64'(0));

      req_mask = '1;
      repeat (400) cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
